// File: rtl/cic_i.sv
// cic_i: CIC interpolator with ORDER low-rate combs, zero-stuffing by INTERPOLATION_RATIO and ORDER full-rate integrators
module cic_i #(
  parameter int DATA_IN_WIDTH       = 8,
  parameter int DATA_OUT_WIDTH      = 8,
  parameter int INTERPOLATION_RATIO = 4,
  parameter int ORDER               = 4,
  parameter int DIFFERENCIAL_DELAY  = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic signed [DATA_IN_WIDTH-1:0]  data_in,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic signed [DATA_OUT_WIDTH-1:0] data_out,
  output logic                             out_dv,
  output logic                             underrun
);
  localparam int R  = INTERPOLATION_RATIO;
  localparam int N  = ORDER;
  localparam int M  = DIFFERENCIAL_DELAY;
  localparam int B  = DATA_IN_WIDTH + $clog2((R * M) ** N / R);
  localparam int PW = $clog2(R);
  localparam int CW = $clog2(N + 1);
  logic [PW-1:0]       phase_q, phase_d;
  logic                accept;
  logic signed [B-1:0] stage_in [N];
  logic signed [B-1:0] comb_out;
  logic signed [B-1:0] dly_q [N][M];
  logic signed [B-1:0] u_q;
  logic signed [B-1:0] acc_q [N];
  logic [CW-1:0]       cnt_q;
  logic                out_dv_q, underrun_q;
  assign accept   = phase_q == '0;
  assign phase_d  = (phase_q == PW'(R - 1)) ? '0 : phase_q + 1'b1;
  assign in_ready = accept & ~reset;
  assign out_dv   = out_dv_q;
  assign underrun = underrun_q;
  assign data_out = acc_q[N-1][B-1 -: DATA_OUT_WIDTH];
  always_comb begin
    comb_out = in_valid ? B'(data_in) : '0;
    for (int k = 0; k < N; k++) begin
      stage_in[k] = comb_out;
      comb_out    = comb_out - dly_q[k][M-1];
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q    <= '0;
      u_q        <= '0;
      cnt_q      <= '0;
      out_dv_q   <= 1'b0;
      underrun_q <= 1'b0;
      for (int k = 0; k < N; k++) begin
        acc_q[k] <= '0;
        for (int j = 0; j < M; j++) dly_q[k][j] <= '0;
      end
    end else begin
      phase_q    <= phase_d;
      underrun_q <= accept & ~in_valid;
      u_q        <= accept ? comb_out : '0;
      if (!out_dv_q) begin
        cnt_q    <= cnt_q + 1'b1;
        out_dv_q <= cnt_q == CW'(N);
      end
      acc_q[0] <= acc_q[0] + u_q;
      for (int k = 1; k < N; k++) acc_q[k] <= acc_q[k] + acc_q[k-1];
      if (accept)
        for (int k = 0; k < N; k++) begin
          dly_q[k][0] <= stage_in[k];
          for (int j = 1; j < M; j++) dly_q[k][j] <= dly_q[k][j-1];
        end
    end
  end
endmodule

// File: tb/tb_cic_i.sv
// tb_cic_i: four cic_i configurations on shared stimulus, checked every cycle against an FIR reference
module tb_cic_i;
  localparam int R    = 4;
  localparam int ND   = 4;
  localparam int HMAX = 64;
  localparam int VMAX = 8192;
  logic              clk      = 1'b0;
  logic              reset    = 1'b1;
  logic              in_valid = 1'b0;
  logic signed [7:0] data_in  = '0;
  logic              rdy  [ND];
  logic signed [7:0] dout [ND];
  logic              dv   [ND];
  logic              ur   [ND];
  int cn [ND] = '{4, 1, 2, 2};
  int cm [ND] = '{1, 1, 1, 2};
  int cb [ND];
  int hl [ND];
  int h  [ND][HMAX];
  int tmp [HMAX];
  int v  [VMAX];
  bit uf [VMAX];
  int ne = 0;
  int ncmp = 0;
  int nerr = 0;
  int nrdy = 0;
  int nur  = 0;
  int zoh_in  [3]  = '{5, 5, -3};
  int zoh_exp [14] = '{0, 5, 5, 5, 5, 5, 5, 5, 5, -3, -3, -3, -3, 0};
  int imp_exp [10] = '{0, 0, 0, 1, 1, 2, 1, 1, 0, 0};
  int hs_vld  [6]  = '{0, 1, 0, 1, 1, 1};
  int hs_val  [6]  = '{0, 3, 0, 5, -7, 9};

  always #5 clk = ~clk;

  cic_i #(.INTERPOLATION_RATIO(R), .ORDER(4), .DIFFERENCIAL_DELAY(1)) u0 (.clk(clk), .reset(reset), .data_in(data_in), .in_valid(in_valid),
    .in_ready(rdy[0]), .data_out(dout[0]), .out_dv(dv[0]), .underrun(ur[0]));
  cic_i #(.INTERPOLATION_RATIO(R), .ORDER(1), .DIFFERENCIAL_DELAY(1)) u1 (.clk(clk), .reset(reset), .data_in(data_in), .in_valid(in_valid),
    .in_ready(rdy[1]), .data_out(dout[1]), .out_dv(dv[1]), .underrun(ur[1]));
  cic_i #(.INTERPOLATION_RATIO(R), .ORDER(2), .DIFFERENCIAL_DELAY(1)) u2 (.clk(clk), .reset(reset), .data_in(data_in), .in_valid(in_valid),
    .in_ready(rdy[2]), .data_out(dout[2]), .out_dv(dv[2]), .underrun(ur[2]));
  cic_i #(.INTERPOLATION_RATIO(R), .ORDER(2), .DIFFERENCIAL_DELAY(2)) u3 (.clk(clk), .reset(reset), .data_in(data_in), .in_valid(in_valid),
    .in_ready(rdy[3]), .data_out(dout[3]), .out_dv(dv[3]), .underrun(ur[3]));

  function automatic int clog2i(int x);
    int k = 0;
    while ((1 << k) < x) k++;
    return k;
  endfunction

  function automatic int model_out(int d, int e);
    longint s = 0;
    longint m;
    for (int j = 0; j < hl[d]; j++)
      if (e - cn[d] - j >= 0) s += longint'(h[d][j]) * longint'(v[e - cn[d] - j]);
    m = s & ((longint'(1) << cb[d]) - 1);
    if (m >= (longint'(1) << (cb[d] - 1))) m -= longint'(1) << cb[d];
    return int'(m >>> (cb[d] - 8));
  endfunction

  task automatic chk(string nm, int d, int act, int exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d t=%0t got %0d expected %0d", nm, d, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (reset) ne = 0;
    else if (ne < VMAX) begin
      v[ne]  = (ne % R == 0 && in_valid) ? int'(data_in) : 0;
      uf[ne] = (ne % R == 0) && !in_valid;
      ne++;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (reset) begin
        chk("rst_rdy", d, int'(rdy[d]), 0);
        chk("rst_dout", d, int'(dout[d]), 0);
        chk("rst_dv", d, int'(dv[d]), 0);
        chk("rst_ur", d, int'(ur[d]), 0);
      end else begin
        chk("rdy", d, int'(rdy[d]), int'(ne % R == 0));
        chk("dv", d, int'(dv[d]), int'(ne - 1 >= cn[d]));
        chk("ur", d, int'(ur[d]), (ne >= 1) ? int'(uf[ne - 1]) : 0);
        chk("dout", d, int'(dout[d]), model_out(d, ne - 1));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    data_in = '0;
    repeat (5) tick();
    reset = 1'b0;
    #1;
    for (int d = 0; d < ND; d++) chk("rel_rdy", d, int'(rdy[d]), 1);
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin
      cb[d] = 8 + clog2i((R * cm[d]) ** cn[d] / R);
      for (int j = 0; j < HMAX; j++) h[d][j] = (j == 0) ? 1 : 0;
      hl[d] = 1;
      repeat (cn[d]) begin
        for (int j = 0; j < HMAX; j++) tmp[j] = h[d][j];
        for (int j = 0; j < HMAX; j++) begin
          h[d][j] = 0;
          for (int i = 0; i < R * cm[d] && i <= j; i++) h[d][j] += tmp[j - i];
        end
        hl[d] += R * cm[d] - 1;
      end
    end
    do_reset();
    in_valid = 1'b1;
    data_in = 8'(7);
    repeat (2) tick();
    chk("pre_rst_dout", 1, int'(dout[1]), 7);
    chk("pre_rst_dv", 1, int'(dv[1]), 1);
    reset = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) begin
      chk("mid_rst_dout", d, int'(dout[d]), 0);
      chk("mid_rst_rdy", d, int'(rdy[d]), 0);
    end
    do_reset();
    for (int i = 0; i < 14; i++) begin
      in_valid = i < 12;
      if (i < 12) data_in = 8'(zoh_in[i / 4]);
      else data_in = '0;
      tick();
      chk("zoh", 1, int'(dout[1]), zoh_exp[i]);
    end
    do_reset();
    for (int i = 0; i < 160; i++) begin
      in_valid = 1'b1;
      data_in = (i < 80) ? 8'(10) : 8'(-128);
      tick();
      if ((i >= 16 && i < 80) || i >= 96)
        for (int d = 0; d < ND; d++) chk("dc", d, int'(dout[d]), (i < 80) ? 10 : -128);
    end
    do_reset();
    for (int i = 0; i < 24; i++) begin
      in_valid = (hs_vld[i / 4] != 0) || (i / 4 == 2 && i % 4 >= 2);
      data_in = (i / 4 == 2) ? 8'(100) : 8'(hs_val[i / 4]);
      if (rdy[0]) nrdy++;
      tick();
      if (ur[0]) nur++;
      if (i >= 9 && i <= 12) chk("hs_ignored", 1, int'(dout[1]), 0);
    end
    chk("rdy_count", 0, nrdy, 6);
    chk("ur_count", 0, nur, 2);
    do_reset();
    for (int i = 0; i < 32; i++) begin
      in_valid = 1'b1;
      data_in = (i < 4) ? 8'(2) : 8'(0);
      tick();
      chk("imp", 2, int'(dout[2]), (i < 10) ? imp_exp[i] : 0);
    end
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      in_valid = 1'b1;
      data_in = ((i / 4) % 2 == 0) ? 8'(127) : 8'(-128);
      tick();
    end
    @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
